mem_arbiter: RTL and testbench

- Two-port arbiter in front of the CPU memory controller.
- Shares the controller's single rd/wr/address/data request interface between the instruction-fetch port and the load/store data port.
- Sequences one transaction at a time: grant, issue, response capture, ack. Honours the controller's hold signal and aborts stalled transfers after a bounded time.
- Sits between the core's fetch and LSU stages and the memory controller.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of the single-request memory controller.
// Build option: define MEM_ARB_DPRIO_EN for fixed data-port priority instead of round-robin.
module mem_arbiter #(
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        mc_rd,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [31:0] mc_wdata,
    input  logic [31:0] mc_data_i,
    input  logic        mc_hold
);

    localparam int              CW     = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]   TMO    = CW'(HOLD_TIMEOUT);
    localparam bit              TMO_EN = (HOLD_TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          grant_d;
    logic          grant_next;
    logic          start;
    logic          abort_now;
    logic          abort_flag;
    logic          op_rd;
    logic [CW-1:0] cnt;
    logic          i_valid;
    logic          d_valid;
`ifndef MEM_ARB_DPRIO_EN
    logic          last_d;
`endif

    // A port's request is masked while its own ack is high; d_rd and d_wr together is not a request.
    assign i_valid = i_req & ~i_ack;
    assign d_valid = (d_rd ^ d_wr) & ~d_ack;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        abort_now  = 1'b0;
        grant_next = grant_d;
        case (state)
            IDLE: begin
                if (i_valid | d_valid) begin
                    start      = 1'b1;
                    state_next = ISSUE;
                    if (i_valid & d_valid) begin
`ifdef MEM_ARB_DPRIO_EN
                        grant_next = 1'b1;
`else
                        grant_next = ~last_d;
`endif
                    end else begin
                        grant_next = d_valid;
                    end
                end
            end
            ISSUE: begin
                if (!mc_hold) begin
                    state_next = RESP;
                end else if (TMO_EN && ((cnt + CW'(1)) == TMO)) begin
                    abort_now  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i_rdata    <= '0;
            i_ack      <= 1'b0;
            i_err      <= 1'b0;
            d_rdata    <= '0;
            d_ack      <= 1'b0;
            d_err      <= 1'b0;
            mc_rd      <= 1'b0;
            mc_wr      <= 1'b0;
            mc_addr    <= '0;
            mc_wdata   <= '0;
            grant_d    <= 1'b0;
            op_rd      <= 1'b0;
            abort_flag <= 1'b0;
            cnt        <= '0;
`ifndef MEM_ARB_DPRIO_EN
            last_d     <= 1'b1;
`endif
        end else begin
            i_ack <= 1'b0;
            i_err <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        grant_d    <= grant_next;
                        op_rd      <= ~grant_next | d_rd;
                        mc_rd      <= ~grant_next | d_rd;
                        mc_wr      <= grant_next & d_wr;
                        mc_addr    <= grant_next ? d_addr : i_addr;
                        mc_wdata   <= (grant_next & d_wr) ? d_wdata : '0;
                        abort_flag <= 1'b0;
                        cnt        <= '0;
                    end
                end
                ISSUE: begin
                    if (!mc_hold || abort_now) begin
                        mc_rd      <= 1'b0;
                        mc_wr      <= 1'b0;
                        abort_flag <= abort_now;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    // An aborted read returns zero rather than whatever the bus carried.
                    if (grant_d) begin
                        d_ack <= 1'b1;
                        d_err <= abort_flag;
                        if (op_rd) d_rdata <= abort_flag ? '0 : mc_data_i;
                    end else begin
                        i_ack   <= 1'b1;
                        i_err   <= abort_flag;
                        i_rdata <= abort_flag ? '0 : mc_data_i;
                    end
                    cnt <= '0;
`ifndef MEM_ARB_DPRIO_EN
                    last_d <= grant_d;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;

    int total = 0;
    int bad   = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_rd, d_wr, mc_hold;
    logic [31:0] i_addr, d_addr, d_wdata, mc_data_i;

    logic [31:0] i_rdata, d_rdata, mc_addr, mc_wdata;
    logic        i_ack, i_err, d_ack, d_err, mc_rd, mc_wr;

    logic [31:0] t_i_rdata, t_d_rdata, t_mc_addr, t_mc_wdata;
    logic        t_i_ack, t_i_err, t_d_ack, t_d_err, t_mc_rd, t_mc_wr;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .mc_rd(mc_rd), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_data_i(mc_data_i), .mc_hold(mc_hold)
    );

    // Short-timeout copy driven by the same inputs, used for the abort scenario.
    mem_arbiter #(.HOLD_TIMEOUT(4)) dut_t (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(t_i_rdata), .i_ack(t_i_ack), .i_err(t_i_err),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(t_d_rdata), .d_ack(t_d_ack), .d_err(t_d_err),
        .mc_rd(t_mc_rd), .mc_wr(t_mc_wr), .mc_addr(t_mc_addr), .mc_wdata(t_mc_wdata),
        .mc_data_i(mc_data_i), .mc_hold(mc_hold)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_req = 0; d_rd = 0; d_wr = 0; mc_hold = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mc_data_i = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        i_req = 1; d_rd = 1; i_addr = 32'h40; d_addr = 32'h80;
        for (int c = 0; c < 3; c++) begin
            if (c < 2) step();
            else rst = 0;
            total++;
            if ({i_ack, i_err, d_ack, d_err, mc_rd, mc_wr, i_rdata, d_rdata, mc_addr, mc_wdata,
                 t_i_ack, t_d_ack, t_mc_rd, t_mc_wr} !== '0) begin
                bad++;
                $display("[TB] FAIL reset_outputs c=%0d: got ack=%b/%b rd=%b wr=%b addr=%h rdata=%h/%h, want all 0",
                         c, i_ack, d_ack, mc_rd, mc_wr, mc_addr, i_rdata, d_rdata);
            end
        end
        step();
        total++;
        if ({mc_rd, mc_wr, mc_addr} !== {1'b1, 1'b0, 32'h40}) begin
            bad++;
            $display("[TB] FAIL reset_first_grant: got rd=%b wr=%b addr=%h, want rd=1 wr=0 addr=00000040",
                     mc_rd, mc_wr, mc_addr);
        end
        i_req = 0; d_rd = 0;
        step(); step(); step();
    endtask

    task automatic test_single_fetch();
        do_reset();
        i_req = 1; i_addr = 32'h100; mc_data_i = 32'h11111111;
        step();
        total++;
        if ({mc_rd, mc_wr, mc_addr} !== {1'b1, 1'b0, 32'h100}) begin
            bad++;
            $display("[TB] FAIL fetch_issue: got rd=%b wr=%b addr=%h, want rd=1 wr=0 addr=00000100", mc_rd, mc_wr, mc_addr);
        end
        step();
        total++;
        if ({mc_rd, i_ack} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL fetch_resp: got rd=%b i_ack=%b, want 0 0", mc_rd, i_ack);
        end
        mc_data_i = 32'hDEADBEEF;
        step();
        total++;
        if ({i_ack, i_err, i_rdata, d_ack} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin
            bad++;
            $display("[TB] FAIL fetch_ack: got ack=%b err=%b rdata=%h d_ack=%b, want 1 0 deadbeef 0",
                     i_ack, i_err, i_rdata, d_ack);
        end
        i_req = 0; mc_data_i = 32'h22222222;
        step();
        total++;
        if ({i_ack, i_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            bad++;
            $display("[TB] FAIL fetch_hold_rdata: got ack=%b rdata=%h, want 0 deadbeef", i_ack, i_rdata);
        end
    endtask

    task automatic test_contention();
        bit first_d;
`ifdef MEM_ARB_DPRIO_EN
        first_d = 1;
`else
        first_d = 0;
`endif
        do_reset();
        i_req = 1; i_addr = 32'h200;
        d_wr = 1; d_addr = 32'h6004; d_wdata = 32'h12345678;
        mc_data_i = 32'h0BADF00D;
        for (int t = 0; t < 2; t++) begin
            bit is_d = (t == 0) ? first_d : !first_d;
            step();
            total++;
            if (is_d ? ({mc_rd, mc_wr, mc_addr, mc_wdata} !== {1'b0, 1'b1, 32'h6004, 32'h12345678})
                     : ({mc_rd, mc_wr, mc_addr} !== {1'b1, 1'b0, 32'h200})) begin
                bad++;
                $display("[TB] FAIL contention_issue t=%0d: got rd=%b wr=%b addr=%h wdata=%h, want %s",
                         t, mc_rd, mc_wr, mc_addr, mc_wdata, is_d ? "wr 6004 12345678" : "rd 200");
            end
            step();
            step();
            total++;
            if (is_d ? ({d_ack, d_err, i_ack} !== 3'b100)
                     : ({i_ack, i_err, d_ack, i_rdata} !== {3'b100, 32'h0BADF00D})) begin
                bad++;
                $display("[TB] FAIL contention_ack t=%0d: got i_ack=%b d_ack=%b errs=%b%b i_rdata=%h, want ack on %s",
                         t, i_ack, d_ack, i_err, d_err, i_rdata, is_d ? "data" : "fetch");
            end
            if (is_d) d_wr = 0;
            else i_req = 0;
        end
        step();
    endtask

    task automatic test_stall();
        do_reset();
        d_rd = 1; d_addr = 32'h3000; mc_hold = 1; mc_data_i = '0;
        for (int j = 1; j <= 6; j++) begin
            step();
            total++;
            if ({mc_rd, mc_wr, mc_addr, d_ack} !== {1'b1, 1'b0, 32'h3000, 1'b0}) begin
                bad++;
                $display("[TB] FAIL stall_hold j=%0d: got rd=%b wr=%b addr=%h d_ack=%b, want 1 0 00003000 0",
                         j, mc_rd, mc_wr, mc_addr, d_ack);
            end
            if (j == 6) mc_hold = 0;
        end
        step();
        total++;
        if ({mc_rd, d_ack} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL stall_resp: got rd=%b d_ack=%b, want 0 0", mc_rd, d_ack);
        end
        mc_data_i = 32'hCAFEF00D;
        step();
        total++;
        if ({d_ack, d_err, d_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
            bad++;
            $display("[TB] FAIL stall_ack: got ack=%b err=%b rdata=%h, want 1 0 cafef00d", d_ack, d_err, d_rdata);
        end
        d_rd = 0;
        step();
    endtask

    task automatic test_timeout();
        int strobes = 0;
        int ack_at  = 0;
        do_reset();
        d_rd = 1; d_addr = 32'h4000;
        step(); step();
        mc_data_i = 32'hA5A5A5A5;
        step();
        total++;
        if ({t_d_ack, t_d_rdata} !== {1'b1, 32'hA5A5A5A5}) begin
            bad++;
            $display("[TB] FAIL timeout_preload: got ack=%b rdata=%h, want 1 a5a5a5a5", t_d_ack, t_d_rdata);
        end
        d_rd = 0;
        step();
        d_rd = 1; d_addr = 32'h4004; mc_hold = 1; mc_data_i = 32'hFFFFFFFF;
        for (int c = 1; c <= 12 && ack_at == 0; c++) begin
            step();
            if (t_mc_rd) strobes++;
            if (t_d_ack) begin
                ack_at = c;
                d_rd = 0;
                total++;
                if ({t_d_err, t_d_rdata} !== {1'b1, 32'h0}) begin
                    bad++;
                    $display("[TB] FAIL timeout_err: got err=%b rdata=%h, want 1 00000000", t_d_err, t_d_rdata);
                end
            end
        end
        total++;
        if (strobes != 4 || ack_at != 6) begin
            bad++;
            $display("[TB] FAIL timeout_timing: got strobes=%0d ack_cycle=%0d, want 4 and 6", strobes, ack_at);
        end
        i_req = 1; i_addr = 32'h500;
        step();
        total++;
        if ({t_mc_rd, t_mc_addr} !== {1'b1, 32'h500}) begin
            bad++;
            $display("[TB] FAIL timeout_idle: got rd=%b addr=%h, want 1 00000500", t_mc_rd, t_mc_addr);
        end
        mc_hold = 0;
        step(); step();
        i_req = 0;
        step();
    endtask

    task automatic test_illegal();
        do_reset();
        d_rd = 1; d_wr = 1; d_addr = 32'h7000; d_wdata = 32'h55;
        for (int c = 0; c < 10; c++) begin
            step();
            total++;
            if ({mc_rd, mc_wr, d_ack, d_err, i_ack} !== 5'b0) begin
                bad++;
                $display("[TB] FAIL illegal_ignored c=%0d: got rd=%b wr=%b d_ack=%b d_err=%b, want all 0",
                         c, mc_rd, mc_wr, d_ack, d_err);
            end
        end
        d_rd = 0; d_wr = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_req = 1; i_addr = 32'h900; mc_hold = 1;
        step();
        total++;
        if (mc_rd !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_issue: got rd=%b, want 1", mc_rd);
        end
        step();
        rst = 1; i_req = 0; mc_hold = 0;
        step();
        total++;
        if ({mc_rd, mc_wr, mc_addr, i_ack} !== '0) begin
            bad++;
            $display("[TB] FAIL midreset_clear: got rd=%b wr=%b addr=%h ack=%b, want all 0", mc_rd, mc_wr, mc_addr, i_ack);
        end
        rst = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            total++;
            if ({i_ack, mc_rd} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL midreset_noack c=%0d: got ack=%b rd=%b, want 0 0", c, i_ack, mc_rd);
            end
        end
    endtask

    // Transaction-level model: one transfer at a time, strobe until a non-held cycle, data the cycle after, ack next.
    task automatic test_random();
        bit          busy = 0, resp = 0, last_d = 1, t_port = 0, t_rd = 0;
        bit          e_rd = 0, e_wr = 0, e_i_ack = 0, e_d_ack = 0, n_i_ack, n_d_ack, vi, vd, pick_d;
        logic [31:0] t_addr = '0, t_wdata = '0, e_i_rdata = '0, e_d_rdata = '0;
        int          hold_run = 0;
        int          done = 0;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (i_req) begin
                if (i_ack) begin
                    if ($urandom_range(1, 0) == 1) i_req = 0;
                    else i_addr = $urandom;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                i_req = 1; i_addr = $urandom;
            end
            if (d_rd && d_wr) begin
                d_rd = 0; d_wr = 0;
            end else if (d_rd || d_wr) begin
                if (d_ack) begin d_rd = 0; d_wr = 0; end
            end else begin
                case ($urandom_range(7, 0))
                    0, 1:    begin d_rd = 1; d_addr = $urandom; end
                    2, 3:    begin d_wr = 1; d_addr = $urandom; d_wdata = $urandom; end
                    4:       begin d_rd = 1; d_wr = 1; d_addr = $urandom; end
                    default: ;
                endcase
            end
            if (hold_run >= 10) mc_hold = 0;
            else mc_hold = ($urandom_range(2, 0) == 0);
            hold_run = mc_hold ? hold_run + 1 : 0;
            mc_data_i = $urandom;

            n_i_ack = 0; n_d_ack = 0;
            if (!busy) begin
                vi = i_req && !e_i_ack;
                vd = (d_rd ^ d_wr) && !e_d_ack;
                if (vi || vd) begin
`ifdef MEM_ARB_DPRIO_EN
                    pick_d = vd;
`else
                    pick_d = vd && (!vi || !last_d);
`endif
                    busy = 1; resp = 0; t_port = pick_d;
                    t_rd = pick_d ? d_rd : 1'b1;
                    t_addr = pick_d ? d_addr : i_addr;
                    t_wdata = d_wdata;
                    e_rd = t_rd; e_wr = !t_rd;
                end
            end else if (!resp) begin
                if (!mc_hold) begin e_rd = 0; e_wr = 0; resp = 1; end
            end else begin
                busy = 0; last_d = t_port; done++;
                if (t_port) begin
                    n_d_ack = 1;
                    if (t_rd) e_d_rdata = mc_data_i;
                end else begin
                    n_i_ack = 1;
                    e_i_rdata = mc_data_i;
                end
            end
            e_i_ack = n_i_ack; e_d_ack = n_d_ack;

            step();
            total++;
            if ({mc_rd, mc_wr} !== {e_rd, e_wr}) begin
                bad++;
                $display("[TB] FAIL rnd_strobe n=%0d: got rd=%b wr=%b, want rd=%b wr=%b", n, mc_rd, mc_wr, e_rd, e_wr);
            end
            if (e_rd || e_wr) begin
                total++;
                if (mc_addr !== t_addr || (e_wr && mc_wdata !== t_wdata)) begin
                    bad++;
                    $display("[TB] FAIL rnd_addr n=%0d: got addr=%h wdata=%h, want addr=%h wdata=%h",
                             n, mc_addr, mc_wdata, t_addr, t_wdata);
                end
            end
            total++;
            if ({i_ack, i_err, d_ack, d_err} !== {e_i_ack, 1'b0, e_d_ack, 1'b0}) begin
                bad++;
                $display("[TB] FAIL rnd_ack n=%0d: got i=%b/%b d=%b/%b, want i_ack=%b d_ack=%b errs 0",
                         n, i_ack, i_err, d_ack, d_err, e_i_ack, e_d_ack);
            end
            total++;
            if (i_rdata !== e_i_rdata || d_rdata !== e_d_rdata) begin
                bad++;
                $display("[TB] FAIL rnd_rdata n=%0d: got i=%h d=%h, want i=%h d=%h", n, i_rdata, d_rdata, e_i_rdata, e_d_rdata);
            end
        end
        total++;
        if (done < 50) begin
            bad++;
            $display("[TB] FAIL rnd_progress: got %0d completed transfers, want at least 50", done);
        end
        clear_inputs();
        step(); step(); step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_stall();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
